// File: rtl/aes_core_arbiter_if.sv
// Requester-side bundle of aes_core_arbiter: per-requester job request channel
// plus the shared response channel with per-requester valid/ready.
interface aes_core_arbiter_if #(
    parameter int N_REQ = 2
);
    logic [N_REQ-1:0]     req_valid;
    logic [N_REQ-1:0]     req_ready;
    logic [N_REQ*128-1:0] req_key;
    logic [N_REQ*128-1:0] req_plaintext;
    logic [N_REQ-1:0]     resp_valid;
    logic [N_REQ-1:0]     resp_ready;
    logic [127:0]         resp_data;
    logic                 resp_err;

    modport master (
        output req_valid, req_key, req_plaintext, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_err
    );

    modport slave (
        input  req_valid, req_key, req_plaintext, resp_ready,
        output req_ready, resp_valid, resp_data, resp_err
    );
endinterface

// File: rtl/aes_core_arbiter.sv
// Round-robin sharing of one aes_core between N_REQ requesters: accepts a job,
// drives the core load/done sequence, and returns the cyphertext to its owner.
module aes_core_arbiter #(
    parameter int N_REQ       = 2,
    parameter int LOAD_CYCLES = 2,
    parameter int TIMEOUT     = 63
) (
    input  logic                       clk,
    input  logic                       reset_n,
    aes_core_arbiter_if.slave          req_if,
    output logic                       core_load,
    output logic [127:0]               core_key,
    output logic [127:0]               core_plaintext,
    input  logic                       core_done,
    input  logic [127:0]               core_cyphertext,
    output logic                       busy,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic [1:0]                 dbg_state
);

    localparam int ID_W = $clog2(N_REQ);
    localparam int LC_W = $clog2(LOAD_CYCLES + 1);
    localparam int RC_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0] grant_id_q, grant_id_d;
    logic [LC_W-1:0] load_cnt_q, load_cnt_d;
    logic [RC_W-1:0] run_cnt_q, run_cnt_d;
    logic            core_load_q, core_load_d;
    logic [127:0]    core_key_q, core_key_d;
    logic [127:0]    core_plaintext_q, core_plaintext_d;
    logic [127:0]    resp_data_q, resp_data_d;
    logic            resp_err_q, resp_err_d;

    logic            pick_found;
    logic [ID_W-1:0] pick_idx;
    logic [ID_W-1:0] cand;
    logic [N_REQ-1:0] req_ready;
    logic [N_REQ-1:0] resp_valid;

    // Search from rr_ptr upward with wrap; iterating backwards lets the
    // closest candidate to rr_ptr overwrite the farther ones.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = ID_W'((int'(rr_ptr_q) + k) % N_REQ);
            if (req_if.req_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Handshakes: a transfer happens on the rising clk edge where valid and
    // ready of the same requester are both high. A requester may withdraw
    // req_valid before that edge; resp_valid/resp_data/resp_err stay put
    // until the owner's resp_ready completes the transfer.
    always_comb begin
        state_d          = state_q;
        rr_ptr_d         = rr_ptr_q;
        grant_id_d       = grant_id_q;
        load_cnt_d       = load_cnt_q;
        run_cnt_d        = run_cnt_q;
        core_load_d      = core_load_q;
        core_key_d       = core_key_q;
        core_plaintext_d = core_plaintext_q;
        resp_data_d      = resp_data_q;
        resp_err_d       = resp_err_q;
        req_ready        = '0;
        resp_valid       = '0;

        case (state_q)
            S_IDLE: begin
                if (pick_found && reset_n) begin
                    req_ready[pick_idx] = 1'b1;
                    core_key_d          = req_if.req_key[int'(pick_idx)*128 +: 128];
                    core_plaintext_d    = req_if.req_plaintext[int'(pick_idx)*128 +: 128];
                    grant_id_d          = pick_idx;
                    core_load_d         = 1'b1;
                    load_cnt_d          = '0;
                    state_d             = S_LOAD;
                end
            end

            S_LOAD: begin
                if (load_cnt_q == LC_W'(LOAD_CYCLES - 1)) begin
                    core_load_d = 1'b0;
                    run_cnt_d   = '0;
                    state_d     = S_RUN;
                end else begin
                    load_cnt_d = load_cnt_q + 1'b1;
                end
            end

            S_RUN: begin
                // The first RUN cycle ignores done: it may still be high from the last job.
                if (run_cnt_q != '0 && core_done) begin
                    resp_data_d = core_cyphertext;
                    resp_err_d  = 1'b0;
                    state_d     = S_RESP;
                end else if (run_cnt_q == RC_W'(TIMEOUT - 1)) begin
                    resp_data_d = '0;
                    resp_err_d  = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    run_cnt_d = run_cnt_q + 1'b1;
                end
            end

            S_RESP: begin
                resp_valid[grant_id_q] = 1'b1;
                if (req_if.resp_ready[grant_id_q]) begin
                    rr_ptr_d = (grant_id_q == ID_W'(N_REQ - 1)) ? '0 : grant_id_q + 1'b1;
                    state_d  = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= S_IDLE;
            rr_ptr_q         <= '0;
            grant_id_q       <= '0;
            load_cnt_q       <= '0;
            run_cnt_q        <= '0;
            core_load_q      <= 1'b0;
            core_key_q       <= '0;
            core_plaintext_q <= '0;
            resp_data_q      <= '0;
            resp_err_q       <= 1'b0;
        end else begin
            state_q          <= state_d;
            rr_ptr_q         <= rr_ptr_d;
            grant_id_q       <= grant_id_d;
            load_cnt_q       <= load_cnt_d;
            run_cnt_q        <= run_cnt_d;
            core_load_q      <= core_load_d;
            core_key_q       <= core_key_d;
            core_plaintext_q <= core_plaintext_d;
            resp_data_q      <= resp_data_d;
            resp_err_q       <= resp_err_d;
        end
    end

    assign req_if.req_ready  = req_ready;
    assign req_if.resp_valid = resp_valid;
    assign req_if.resp_data  = resp_data_q;
    assign req_if.resp_err   = resp_err_q;
    assign core_load         = core_load_q;
    assign core_key          = core_key_q;
    assign core_plaintext    = core_plaintext_q;
    assign busy              = (state_q != S_IDLE);
    assign grant_id          = grant_id_q;
    assign dbg_state         = state_q;

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Directed bench for aes_core_arbiter with a table-driven aes_core stand-in
// that can hang, return promptly, or leave a stale done across a new load.
module tb_aes_core_arbiter;

    localparam int N           = 2;
    localparam int LOAD_CYCLES = 2;
    localparam int TIMEOUT     = 63;
    localparam int STUB_LAT    = 20;

    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset_n;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    aes_core_arbiter_if #(.N_REQ(N)) bif ();

    logic         core_load;
    logic [127:0] core_key;
    logic [127:0] core_plaintext;
    logic         stub_done;
    logic [127:0] stub_ct;
    logic         busy;
    logic [0:0]   grant_id;
    logic [1:0]   dbg_state;

    aes_core_arbiter #(
        .N_REQ       (N),
        .LOAD_CYCLES (LOAD_CYCLES),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .req_if          (bif),
        .core_load       (core_load),
        .core_key        (core_key),
        .core_plaintext  (core_plaintext),
        .core_done       (stub_done),
        .core_cyphertext (stub_ct),
        .busy            (busy),
        .grant_id        (grant_id),
        .dbg_state       (dbg_state)
    );

    // ---------------- aes_core stand-in ----------------
    function automatic logic [127:0] aes_ref(input logic [127:0] k, input logic [127:0] p);
        if (k == KEY_C1 && p == PT_C1) return CT_C1;
        if (k == KEY_B && p == PT_B) return CT_B;
        return k ^ p;
    endfunction

    bit          stub_hang;
    bit          stub_stale;
    int unsigned since_load;
    initial begin
        stub_done = 1'b0;
        stub_ct   = '0;
    end

    // Done rises STUB_LAT cycles into RUN and holds until the next load;
    // in stale mode it survives the load and clears after the first RUN cycle.
    always @(posedge clk) begin
        if (core_load) begin
            since_load <= 0;
            if (!stub_stale) stub_done <= 1'b0;
        end else begin
            since_load <= since_load + 1;
            if (stub_stale && since_load == 0) stub_done <= 1'b0;
            if (!stub_hang && since_load == STUB_LAT - 1) begin
                stub_done <= 1'b1;
                stub_ct   <= aes_ref(core_key, core_plaintext);
            end
        end
    end

    int load_len;
    int last_load_len;
    always @(negedge clk) begin
        if (core_load) begin
            load_len <= load_len + 1;
        end else if (load_len != 0) begin
            last_load_len <= load_len;
            load_len      <= 0;
        end
    end

    // ---------------- scoreboard ----------------
    int n_cmp;
    int n_mis;
    logic [127:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic issue(input int r, input logic [127:0] k, input logic [127:0] p);
        bit acc;
        acc = 1'b0;
        bif.req_key[128*r +: 128]       = k;
        bif.req_plaintext[128*r +: 128] = p;
        bif.req_valid[r]                = 1'b1;
        for (int i = 0; i < 400; i++) begin
            #1;
            acc = bif.req_ready[r];
            @(negedge clk);
            if (acc) break;
        end
        bif.req_valid[r] = 1'b0;
        check_eq("req_accept", 128'(acc), 128'd1);
        check_eq("load_after_hs", 128'({core_load, dbg_state}), 128'({1'b1, ST_LOAD}));
    endtask

    task automatic wait_resp(output logic [127:0] d, output logic e, output logic [N-1:0] vld, output int gid);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            #1;
            if (bif.resp_valid != '0) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        d   = bif.resp_data;
        e   = bif.resp_err;
        vld = bif.resp_valid;
        gid = int'(grant_id);
        check_eq("resp_seen", 128'(seen), 128'd1);
        bif.resp_ready = bif.resp_valid;
        @(negedge clk);
        bif.resp_ready = '0;
    endtask

    task automatic wait_run(input string tag);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (dbg_state == ST_RUN) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check_eq(tag, 128'(found), 128'd1);
    endtask

    // ---------------- directed sequence ----------------
    logic [127:0] d;
    logic         e;
    logic [N-1:0] vld;
    int           gid;
    int           cnt;
    int           bad_data;
    int           bad_ready;
    int           bad_valid;

    initial begin
        reset_n           = 1'b0;
        bif.req_valid     = '0;
        bif.req_key       = '0;
        bif.req_plaintext = '0;
        bif.resp_ready    = '0;
        stub_hang         = 1'b0;
        stub_stale        = 1'b0;

        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_ctl", 128'({core_load, busy, grant_id, dbg_state, bif.req_ready, bif.resp_valid, bif.resp_err}), 128'd0);
        check_eq("rst_key", core_key, 128'd0);
        check_eq("rst_pt", core_plaintext, 128'd0);
        check_eq("rst_data", bif.resp_data, 128'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Both requesters continuously valid: grants alternate from requester 0.
        exp_q             = {CT_C1, CT_B, CT_C1, CT_B};
        bif.req_key       = {KEY_B, KEY_C1};
        bif.req_plaintext = {PT_B, PT_C1};
        bif.req_valid     = 2'b11;
        for (int j = 0; j < 4; j++) begin
            wait_resp(d, e, vld, gid);
            check_eq("rr_valid", 128'(vld), 128'(2'b01 << (j % 2)));
            check_eq("rr_grant", 128'(gid), 128'(j % 2));
            check_eq("rr_data", d, exp_q.pop_front());
            check_eq("rr_err", 128'(e), 128'd0);
        end
        bif.req_valid = '0;

        // FIPS-197 C.1 through requester 0.
        issue(0, KEY_C1, PT_C1);
        wait_resp(d, e, vld, gid);
        check_eq("c1_valid", 128'(vld), 128'(2'b01));
        check_eq("c1_data", d, CT_C1);
        check_eq("c1_err", 128'(e), 128'd0);
        check_eq("c1_load_len", 128'(last_load_len), 128'(LOAD_CYCLES));

        // Core never finishes: error response exactly TIMEOUT cycles into RUN.
        stub_hang = 1'b1;
        issue(0, KEY_C1, PT_C1);
        wait_run("to_run_seen");
        cnt = 0;
        while (!bif.resp_valid[0] && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        check_eq("to_cycles", 128'(cnt), 128'(TIMEOUT));
        wait_resp(d, e, vld, gid);
        check_eq("to_err", 128'(e), 128'd1);
        check_eq("to_data", d, 128'd0);
        stub_hang = 1'b0;
        issue(1, KEY_B, PT_B);
        wait_resp(d, e, vld, gid);
        check_eq("after_to_valid", 128'(vld), 128'(2'b10));
        check_eq("after_to_data", d, CT_B);
        check_eq("after_to_err", 128'(e), 128'd0);

        // Back-pressure on the response while both requesters wait.
        issue(0, KEY_C1, PT_C1);
        cnt = 0;
        while (!bif.resp_valid[0] && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        check_eq("hold_resp_seen", 128'(bif.resp_valid[0]), 128'd1);
        bif.req_key       = {KEY_B, KEY_C1};
        bif.req_plaintext = {PT_B, PT_C1};
        bif.req_valid     = 2'b11;
        bif.resp_ready    = 2'b10;
        bad_data  = 0;
        bad_ready = 0;
        bad_valid = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (bif.resp_data !== CT_C1) bad_data++;
            if (bif.req_ready !== 2'b00) bad_ready++;
            if (bif.resp_valid !== 2'b01) bad_valid++;
        end
        check_eq("hold_data_stable", 128'(bad_data), 128'd0);
        check_eq("hold_req_ready_low", 128'(bad_ready), 128'd0);
        check_eq("hold_valid_kept", 128'(bad_valid), 128'd0);
        bif.resp_ready = 2'b01;
        @(negedge clk);
        bif.resp_ready = '0;
        #1;
        check_eq("hold_next_pick", 128'(bif.req_ready), 128'(2'b10));
        @(negedge clk);
        check_eq("hold_next_grant", 128'({dbg_state, grant_id}), 128'({ST_LOAD, 1'b1}));
        bif.req_valid = '0;
        wait_resp(d, e, vld, gid);
        check_eq("hold_next_valid", 128'(vld), 128'(2'b10));
        check_eq("hold_next_data", d, CT_B);

        // Asynchronous reset in the middle of RUN.
        issue(0, KEY_C1, PT_C1);
        wait_run("rst_run_seen");
        repeat (3) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("async_rst_ctl", 128'({core_load, busy, grant_id, dbg_state, bif.req_ready, bif.resp_valid, bif.resp_err}), 128'd0);
        check_eq("async_rst_key", core_key, 128'd0);
        check_eq("async_rst_pt", core_plaintext, 128'd0);
        check_eq("async_rst_data", bif.resp_data, 128'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        issue(0, KEY_C1, PT_C1);
        wait_resp(d, e, vld, gid);
        check_eq("post_rst_valid", 128'(vld), 128'(2'b01));
        check_eq("post_rst_data", d, CT_C1);

        // Done still high from the previous job when the new one enters RUN.
        stub_stale = 1'b1;
        issue(1, KEY_B, PT_B);
        wait_resp(d, e, vld, gid);
        check_eq("stale_valid", 128'(vld), 128'(2'b10));
        check_eq("stale_data", d, CT_B);
        check_eq("stale_err", 128'(e), 128'd0);
        stub_stale = 1'b0;

        @(negedge clk);
        check_eq("end_idle", 128'({busy, dbg_state}), 128'({1'b0, ST_IDLE}));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, limit 2000000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
